// File: rtl/mul_fp64_arb.sv
// Round-robin front end sharing one fixed-latency fp64 multiplier among NREQ requesters,
// with a tag pipe that follows the multiplier and a credit-limited response FIFO.
`timescale 1ns/1ps
module mul_fp64_arb #(
  parameter int NREQ  = 4,
  parameter int LAT   = 4,
  parameter int DEPTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_rm,
  input  logic [64*NREQ-1:0]   req_src1,
  input  logic [64*NREQ-1:0]   req_src2,
  output logic                 mul_en,
  output logic [2:0]           mul_rm,
  output logic [63:0]          mul_src1,
  output logic [63:0]          mul_src2,
  input  logic [63:0]          mul_result,
  input  logic                 mul_nv,
  input  logic                 mul_of,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_result,
  output logic                 rsp_nv,
  output logic                 rsp_of
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(LAT + 1);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [FW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LAT-1:0] tag_v_q, tag_v_d;
  logic [IDW-1:0] tag_id_q [LAT];

  logic [IDW-1:0] mem_id  [DEPTH];
  logic [63:0]    mem_res [DEPTH];
  logic           mem_nv  [DEPTH];
  logic           mem_of  [DEPTH];

  logic           found;
  logic [IDW-1:0] gnt_id;
  int             idx;
  logic           space;
  logic           issue;
  logic           tag_v;
  logic [IDW-1:0] tag_id;
  logic           push;
  logic           pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // First valid requester at or after ptr_q, wrapping around.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
  end

  // Registered counts only: a pop this cycle frees credit next cycle.
  assign space = (int'(fifo_cnt_q) + int'(inflight_q)) < DEPTH;
  assign issue = found & space & ~reset;
  assign mul_en = issue;

  always_comb begin
    req_ready = '0;
    if (issue) req_ready[gnt_id] = 1'b1;
    mul_rm   = '0;
    mul_src1 = '0;
    mul_src2 = '0;
    if (found) begin
      mul_rm   = req_rm[int'(gnt_id)*3 +: 3];
      mul_src1 = req_src1[int'(gnt_id)*64 +: 64];
      mul_src2 = req_src2[int'(gnt_id)*64 +: 64];
    end
  end

  assign tag_v  = tag_v_q[LAT-1];
  assign tag_id = tag_id_q[LAT-1];
  assign push   = tag_v;
  assign pop    = rsp_valid & rsp_ready;

  always_comb begin
    ptr_d = ptr_q;
    if (issue) ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);

    tag_v_d = LAT'({tag_v_q, issue});

    inflight_d = inflight_q;
    if (issue && !tag_v)      inflight_d = inflight_q + FW'(1);
    else if (!issue && tag_v) inflight_d = inflight_q - FW'(1);

    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CW'(1);
    else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CW'(1);

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_v_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_v_q    <= tag_v_d;
    end
  end

  // Payload storage needs no reset; validity lives in tag_v_q and the FIFO count.
  always_ff @(posedge clock) begin
    tag_id_q[0] <= gnt_id;
    for (int i = 1; i < LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
    if (push) begin
      mem_id[wr_ptr_q]  <= tag_id;
      mem_res[wr_ptr_q] <= mul_result;
      mem_nv[wr_ptr_q]  <= mul_nv;
      mem_of[wr_ptr_q]  <= mul_of;
    end
  end

  assign rsp_valid  = (fifo_cnt_q != '0) & ~reset;
  assign rsp_id     = mem_id[rd_ptr_q];
  assign rsp_result = mem_res[rd_ptr_q];
  assign rsp_nv     = mem_nv[rd_ptr_q];
  assign rsp_of     = mem_of[rd_ptr_q];

endmodule

// File: tb/tb_mul_fp64_arb.sv
// Scoreboard bench for mul_fp64_arb: a behavioural multiplier drives the result side,
// an arbitration/credit model predicts grants, and a monitor checks responses in order.
`timescale 1ns/1ps
module tb_mul_fp64_arb;
  localparam int NREQ = 4, LAT = 4, DEPTH = 8, IDW = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [3*NREQ-1:0]  req_rm;
  logic [64*NREQ-1:0] req_src1, req_src2;
  logic               mul_en;
  logic [2:0]         mul_rm;
  logic [63:0]        mul_src1, mul_src2, mul_result;
  logic               mul_nv, mul_of;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [IDW-1:0]     rsp_id;
  logic [63:0]        rsp_result;
  logic               rsp_nv, rsp_of;

  logic [63:0]     op_a [NREQ];
  logic [63:0]     op_b [NREQ];
  logic [2:0]      op_rm [NREQ];
  logic [NREQ-1:0] vld = '0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    res;
    logic           nv;
    logic           of;
    int             avail;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, m_ptr = 0, issued = 0, popped = 0, popped_snap = 0, hs_cnt = 0, n_rsp = 0;
  int last_iss_cyc = 0, last_pop_cyc = 0;
  logic [NREQ-1:0] acc_vec = '0;
  logic [IDW-1:0]  last_id;
  logic [63:0]     last_res;
  logic            last_nv, last_of;
  logic [65:0]     mp [LAT];

  mul_fp64_arb #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rm(req_rm),
    .req_src1(req_src1), .req_src2(req_src2),
    .mul_en(mul_en), .mul_rm(mul_rm), .mul_src1(mul_src1), .mul_src2(mul_src2),
    .mul_result(mul_result), .mul_nv(mul_nv), .mul_of(mul_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_nv(rsp_nv), .rsp_of(rsp_of)
  );

  always #5 clock = ~clock;

  always_comb begin
    req_valid = vld;
    for (int i = 0; i < NREQ; i++) begin
      req_src1[i*64 +: 64] = op_a[i];
      req_src2[i*64 +: 64] = op_b[i];
      req_rm[i*3 +: 3]     = op_rm[i];
    end
  end

  // IEEE double multiply (round to nearest) with invalid/overflow flags; NaN results are canonical.
  function automatic logic [65:0] fmul(input logic [63:0] a, input logic [63:0] b);
    logic inf_a, inf_b, nan_a, nan_b, zero_a, zero_b, nv, of;
    logic [63:0] r;
    inf_a  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
    inf_b  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
    nan_a  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
    nan_b  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
    zero_a = (a[62:0] == 63'd0);
    zero_b = (b[62:0] == 63'd0);
    nv = (inf_a && zero_b) || (zero_a && inf_b) || (nan_a && !a[51]) || (nan_b && !b[51]);
    if (nv || nan_a || nan_b) return {nv, 1'b0, 64'h7FF8000000000000};
    r  = $realtobits($bitstoreal(a) * $bitstoreal(b));
    of = (r[62:52] == 11'h7FF) && !inf_a && !inf_b;
    return {1'b0, of, r};
  endfunction

  function automatic logic [63:0] rnd_fp();
    logic [63:0] v;
    v[63]    = 1'($urandom_range(0, 1));
    v[62:52] = 11'($urandom_range(900, 1100));
    v[51:32] = 20'($urandom);
    v[31:0]  = $urandom;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
    end
  endtask

  // Environment multiplier: fixed latency, no stall, not reset.
  always @(posedge clock) begin
    for (int i = LAT - 1; i > 0; i--) mp[i] <= mp[i-1];
    mp[0] <= fmul(mul_src1, mul_src2);
  end
  assign {mul_nv, mul_of, mul_result} = mp[LAT-1];

  always @(posedge clock) begin
    cyc++;
    popped_snap = popped;
  end

  // Issue side: predict the grant from round-robin + credit, push expected responses.
  always @(negedge clock) begin : issue_model
    int g;
    bit f, sp;
    logic [NREQ-1:0] er;
    logic [65:0] r;
    if (reset) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_mul_en", 64'(mul_en), 64'd0);
      exp_q.delete();
      m_ptr   = 0;
      issued  = 0;
      acc_vec = '0;
    end else begin
      f = 1'b0;
      g = 0;
      for (int k = 0; k < NREQ; k++)
        if (!f && vld[(m_ptr + k) % NREQ]) begin
          f = 1'b1;
          g = (m_ptr + k) % NREQ;
        end
      sp = (issued - popped_snap) < DEPTH;
      er = (f && sp) ? (NREQ'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("mul_en", 64'(mul_en), 64'(f && sp));
      chk("mul_src1", mul_src1, f ? op_a[g] : 64'd0);
      chk("mul_src2", mul_src2, f ? op_b[g] : 64'd0);
      chk("mul_rm", 64'(mul_rm), f ? 64'(op_rm[g]) : 64'd0);
      acc_vec = req_valid & req_ready;
      hs_cnt += $countones(acc_vec);
      if (f && sp) begin
        r = fmul(op_a[g], op_b[g]);
        exp_q.push_back('{id: IDW'(g), res: r[63:0], nv: r[65], of: r[64], avail: cyc + LAT + 1});
        m_ptr = (g + 1) % NREQ;
        issued++;
        last_iss_cyc = cyc;
      end
    end
  end

  // Response monitor: head must appear exactly when its result has been captured, and stay put until popped.
  always @(negedge clock) begin : rsp_monitor
    bit ev;
    if (reset) begin
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      popped = 0;
    end else begin
      ev = (exp_q.size() > 0) && (exp_q[0].avail <= cyc);
      chk("rsp_valid", 64'(rsp_valid), 64'(ev));
      if (rsp_valid && ev) begin
        chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
        chk("rsp_result", rsp_result, exp_q[0].res);
        chk("rsp_nv", 64'(rsp_nv), 64'(exp_q[0].nv));
        chk("rsp_of", 64'(rsp_of), 64'(exp_q[0].of));
        if (rsp_ready) begin
          last_id      = rsp_id;
          last_res     = rsp_result;
          last_nv      = rsp_nv;
          last_of      = rsp_of;
          last_pop_cyc = cyc;
          void'(exp_q.pop_front());
          popped++;
          n_rsp++;
        end
      end
    end
  end

  task automatic step(input logic [NREQ-1:0] mask, input int rmode);
    @(posedge clock);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        if (!vld[i] || acc_vec[i]) begin
          op_a[i]  = rnd_fp();
          op_b[i]  = rnd_fp();
          op_rm[i] = 3'($urandom_range(0, 4));
          vld[i]   = 1'b1;
        end
      end else begin
        vld[i] = 1'b0;
      end
    end
    case (rmode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      2:       rsp_ready = (cyc % 3 == 0);
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic run(input logic [NREQ-1:0] mask, input int n, input int rmode);
    repeat (n) step(mask, rmode);
  endtask

  task automatic one_shot(input int id, input logic [63:0] a, input logic [63:0] b, input logic [2:0] rm);
    bit got;
    int n0;
    @(posedge clock);
    #1;
    vld       = '0;
    op_a[id]  = a;
    op_b[id]  = b;
    op_rm[id] = rm;
    vld[id]   = 1'b1;
    rsp_ready = 1'b1;
    n0  = n_rsp;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(posedge clock);
      #1;
      if (acc_vec[id]) got = 1'b1;
    end
    vld[id] = 1'b0;
    chk("accept_timeout", 64'(got), 64'd1);
    got = 1'b0;
    for (int t = 0; t < 30 && !got; t++) begin
      @(posedge clock);
      #1;
      if (n_rsp > n0) got = 1'b1;
    end
    chk("response_timeout", 64'(got), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      op_a[i]  = '0;
      op_b[i]  = '0;
      op_rm[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    run('0, 2, 1);

    one_shot(2, 64'h3FF8000000000000, 64'h4000000000000000, 3'd0);
    chk("single_id", 64'(last_id), 64'd2);
    chk("single_result", last_res, 64'h4008000000000000);
    chk("single_nv", 64'(last_nv), 64'd0);
    chk("single_of", 64'(last_of), 64'd0);
    chk("single_latency", 64'(last_pop_cyc - last_iss_cyc), 64'(LAT + 1));

    run('1, 40, 1);
    run('0, 12, 1);

    hs_cnt = 0;
    run('1, 20, 0);
    chk("bp_issue_count", 64'(hs_cnt), 64'(DEPTH));
    run('1, 30, 1);

    run('1, 12, 0);
    run('1, 45, 2);
    run('0, 15, 1);

    run(4'b0010, 3, 1);
    run('0, 1, 1);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = rnd_fp();
      op_b[i] = rnd_fp();
    end
    vld = '1;
    @(negedge clock);
    #1 chk("post_reset_grant", 64'(acc_vec), 64'b0001);
    run('1, 20, 1);
    run('0, 12, 1);

    one_shot(1, 64'h0000000000000000, 64'h7FF0000000000000, 3'd0);
    chk("nan_id", 64'(last_id), 64'd1);
    chk("nan_exp", 64'(last_res[62:52]), 64'h7FF);
    chk("nan_msb", 64'(last_res[51]), 64'd1);
    chk("nan_nv", 64'(last_nv), 64'd1);

    repeat (20) run(NREQ'($urandom_range(0, 15)), 15, 3);
    run('0, 30, 1);
    chk("drain_outstanding", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
